// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic array control path.
package tpu_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_SETTLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } ctrl_state_t;

endpackage

// File: rtl/systolic_ctrl_sa_skew.sv
// Per-row delay line: row r of the output is row r of the input delayed r cycles.
module sa_skew #(
    parameter int ROWS = 2
) (
    input  logic            clk,
    input  logic            i_clr,
    input  logic [ROWS-1:0] i_in,
    output logic [ROWS-1:0] o_out
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        if (r == 0) begin : g_pass
            assign o_out[0] = i_in[0];
        end else begin : g_dly
            localparam int D = r;
            logic [D-1:0] r_sh;

            always_ff @(posedge clk) begin
                if (i_clr) begin
                    r_sh <= '0;
                end else begin
                    r_sh <= (r_sh << 1) | D'(i_in[r]);
                end
            end

            assign o_out[r] = r_sh[D-1];
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Systolic array sequencer: weight load, skewed input streaming, result-valid tracking.
// Optional busy-cycle counter enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl
    import tpu_pkg::*;
#(
    parameter int ROWS    = 2,
    parameter int COLS    = 2,
    parameter int MAX_VEC = 256,
    parameter int VEC_W   = $clog2(MAX_VEC + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [VEC_W-1:0]        num_vec,
    output logic                    busy,
    output logic                    done,
    output logic                    wbuf_rd_en,
    output logic [$clog2(ROWS)-1:0] wbuf_rd_addr,
    output logic                    ibuf_rd_en,
    output logic [VEC_W-1:0]        ibuf_rd_addr,
    output logic                    sa_enabled,
    output logic [COLS-1:0]         sa_accept_w,
    output logic [ROWS-1:0]         sa_valid,
    output logic [ROWS-1:0]         sa_switch,
    output logic [COLS-1:0]         out_valid,
    output logic [31:0]             perf_cycles
);

    localparam int AW    = $clog2(ROWS);
    localparam int DR_W  = $clog2(ROWS + COLS);
    localparam int CNT_W = (VEC_W > DR_W) ? VEC_W : DR_W;

    ctrl_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [VEC_W-1:0] r_n, w_n_clamp;
    logic             w_accept_start, w_clr;
    logic             r_acc, r_vld, r_sw;
    logic [COLS-1:0]  r_ov;

    assign w_n_clamp      = (num_vec > VEC_W'(MAX_VEC)) ? VEC_W'(MAX_VEC) : num_vec;
    assign w_accept_start = (r_state == S_IDLE) && start && !abort;
    assign w_clr          = rst || (abort && (r_state != S_IDLE));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_accept_start) begin
                    w_state_nxt = (w_n_clamp == '0) ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (r_cnt == CNT_W'(ROWS - 1)) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_SETTLE: begin
                if (r_cnt == CNT_W'(ROWS - 1)) begin
                    w_state_nxt = S_STREAM;
                    w_cnt_nxt   = '0;
                end
            end
            S_STREAM: begin
                if (r_cnt == CNT_W'(r_n) - CNT_W'(1)) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = '0;
                end
            end
            // Last column sees its last result ROWS+COLS cycles after streaming ends
            S_DRAIN: begin
                if (r_cnt == CNT_W'(ROWS + COLS - 1)) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_n     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept_start) begin
                r_n <= w_n_clamp;
            end
        end
    end

    // One-cycle delay aligns control flags with the buffers' read data
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_acc <= 1'b0;
            r_vld <= 1'b0;
            r_sw  <= 1'b0;
            r_ov  <= '0;
        end else begin
            r_acc <= (r_state == S_LOAD_W);
            r_vld <= (r_state == S_STREAM);
            r_sw  <= (r_state == S_STREAM) && (r_cnt == '0);
            r_ov  <= (r_ov << 1) | COLS'(sa_valid[ROWS-1]);
        end
    end

    sa_skew #(.ROWS(ROWS)) u_skew_valid (
        .clk   (clk),
        .i_clr (w_clr),
        .i_in  ({ROWS{r_vld}}),
        .o_out (sa_valid)
    );

    sa_skew #(.ROWS(ROWS)) u_skew_switch (
        .clk   (clk),
        .i_clr (w_clr),
        .i_in  ({ROWS{r_sw}}),
        .o_out (sa_switch)
    );

    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign sa_enabled   = busy && (r_n != '0);
    assign wbuf_rd_en   = (r_state == S_LOAD_W);
    assign wbuf_rd_addr = wbuf_rd_en ? r_cnt[AW-1:0] : '0;
    assign ibuf_rd_en   = (r_state == S_STREAM);
    assign ibuf_rd_addr = ibuf_rd_en ? r_cnt[VEC_W-1:0] : '0;
    assign sa_accept_w  = {COLS{r_acc}};
    assign out_valid    = r_ov;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (rst || w_accept_start) begin
            r_perf <= '0;
        end else if (busy) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: run-level timing model feeds a queue, negedge monitor compares.
module tb_systolic_ctrl;

    localparam int R    = 2;
    localparam int C    = 2;
    localparam int MAXV = 256;
    localparam int VW   = $clog2(MAXV + 1);

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [VW-1:0] num_vec;
    logic          busy, done, wbuf_rd_en, ibuf_rd_en, sa_enabled;
    logic [0:0]    wbuf_rd_addr;
    logic [VW-1:0] ibuf_rd_addr;
    logic [C-1:0]  sa_accept_w, out_valid;
    logic [R-1:0]  sa_valid, sa_switch;
    logic [31:0]   perf_cycles;

    systolic_ctrl #(.ROWS(R), .COLS(C), .MAX_VEC(MAXV)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .num_vec      (num_vec),
        .busy         (busy),
        .done         (done),
        .wbuf_rd_en   (wbuf_rd_en),
        .wbuf_rd_addr (wbuf_rd_addr),
        .ibuf_rd_en   (ibuf_rd_en),
        .ibuf_rd_addr (ibuf_rd_addr),
        .sa_enabled   (sa_enabled),
        .sa_accept_w  (sa_accept_w),
        .sa_valid     (sa_valid),
        .sa_switch    (sa_switch),
        .out_valid    (out_valid),
        .perf_cycles  (perf_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int busy, done, en, wen, waddr, acc, ien, iaddr, vld, sw, ov, perf;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model: one run described by its first cycle, length and end cycle
    int m_t = 0, m_active = 0, m_L0 = 0, m_N = 0, m_dn = 0, m_perf = 0;
    int d_start = 0, d_abort = 0, d_rst = 0, d_num = 0;

    function automatic exp_t expect_at(int t);
        exp_t e;
        int d, k;
        e = '{default: 0};
        e.t = t;
`ifdef SYSTOLIC_CTRL_PERF_EN
        e.perf = m_perf;
`endif
        if (m_active != 0 && t <= m_dn) begin
            d = t - m_L0;
            k = d - 2 * R;
            e.busy = 1;
            e.done = (t == m_dn);
            if (m_N > 0) begin
                e.en    = 1;
                e.wen   = (d < R);
                e.waddr = (d < R) ? d : 0;
                e.acc   = (d >= 1 && d <= R) ? (1 << C) - 1 : 0;
                e.ien   = (k >= 0 && k < m_N);
                e.iaddr = e.ien ? k : 0;
                for (int r = 0; r < R; r++) begin
                    if (k - 1 - r >= 0 && k - 1 - r < m_N) e.vld |= (1 << r);
                    if (k == 1 + r) e.sw |= (1 << r);
                end
                for (int c = 0; c < C; c++) begin
                    if (k - 1 - R - c >= 0 && k - 1 - R - c < m_N) e.ov |= (1 << c);
                end
            end
        end
        return e;
    endfunction

    task automatic model_edge();
        int busy_prev;
        m_t++;
        busy_prev = (m_active != 0 && m_t - 1 <= m_dn);
        if (d_rst != 0) begin
            m_active = 0;
            m_perf   = 0;
        end else if (busy_prev != 0) begin
            m_perf++;
            if (d_abort != 0 || m_t - 1 == m_dn) m_active = 0;
        end else begin
            m_active = 0;
            if (d_start != 0 && d_abort == 0) begin
                m_active = 1;
                m_L0     = m_t;
                m_N      = (d_num > MAXV) ? MAXV : d_num;
                m_dn     = (m_N == 0) ? m_L0 : m_L0 + 3 * R + C + m_N;
                m_perf   = 0;
            end
        end
        q.push_back(expect_at(m_t));
    endtask

    task automatic step(input int s, input int a, input int r, input int n);
        d_start = s; d_abort = a; d_rst = r; d_num = n;
        start   = (s != 0);
        abort   = (a != 0);
        rst     = (r != 0);
        num_vec = VW'(n);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input int t, input int act, input int req);
        n_assert++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, t, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("busy",        e.t, int'(busy),        e.busy);
            chk("done",        e.t, int'(done),        e.done);
            chk("sa_enabled",  e.t, int'(sa_enabled),  e.en);
            chk("wbuf_rd_en",  e.t, int'(wbuf_rd_en),  e.wen);
            chk("sa_accept_w", e.t, int'(sa_accept_w), e.acc);
            chk("ibuf_rd_en",  e.t, int'(ibuf_rd_en),  e.ien);
            chk("sa_valid",    e.t, int'(sa_valid),    e.vld);
            chk("sa_switch",   e.t, int'(sa_switch),   e.sw);
            chk("out_valid",   e.t, int'(out_valid),   e.ov);
            chk("perf_cycles", e.t, int'(perf_cycles), e.perf);
            if (e.wen != 0 || e.busy == 0)
                chk("wbuf_rd_addr", e.t, int'(wbuf_rd_addr), e.waddr);
            if (e.ien != 0 || e.busy == 0)
                chk("ibuf_rd_addr", e.t, int'(ibuf_rd_addr), e.iaddr);
        end
    end

    initial begin
        int s, a, r, n;
        start = 1'b0; abort = 1'b0; rst = 1'b1; num_vec = '0;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        idle(2);

        // Basic run, N=3
        step(1, 0, 0, 3);
        idle(15);
        // Zero-length run
        step(1, 0, 0, 0);
        idle(4);
        // Oversized request is clamped
        step(1, 0, 0, 300);
        idle(275);
        // Start during STREAM is ignored
        step(1, 0, 0, 3);
        idle(5);
        step(1, 0, 0, 7);
        idle(10);
        // Abort in the first STREAM-adjacent cycle
        step(1, 0, 0, 3);
        idle(5);
        step(0, 1, 0, 0);
        idle(4);
        // Abort together with start while idle
        step(1, 1, 0, 3);
        idle(3);
        // Reset mid-DRAIN, then a fresh run
        step(1, 0, 0, 3);
        idle(8);
        step(0, 0, 1, 0);
        idle(2);
        step(1, 0, 0, 3);
        idle(15);

        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 40) == 0);
            r = ($urandom_range(0, 150) == 0);
            n = ($urandom_range(0, 40) == 0) ? $urandom_range(250, 511) : $urandom_range(0, 9);
            step(s, a, r, n);
        end
        idle(300);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", m_t, q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the PE systolic array. On each `start` it:
- loads one weight tile from the weight buffer into the array's inactive weight registers;
- streams `num_vec` input vectors in from the west with per-row skew, pulsing `switch` with the first vector so the loaded weights go active;
- flags when each column's result leaves the bottom row.

It sits between the top-level command logic, the weight/input buffers, and the PE array's north/west edge signals.

## Interface
- `ROWS`, 2, PE rows (input lanes / weight words per tile)
- `COLS`, 2, PE columns
- `MAX_VEC`, 256, max vectors per run
- `VEC_W`, $clog2(MAX_VEC+1), width of `num_vec`
- `clk` in 1: single clock; all logic on its rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle request; sampled only in IDLE
- `abort` in 1: synchronous cancel of the current run
- `num_vec` in VEC_W: vectors in this run; sampled with `start`
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse in DONE
- `wbuf_rd_en` out 1, `wbuf_rd_addr` out $clog2(ROWS): weight buffer read, 1-cycle read latency
- `ibuf_rd_en` out 1, `ibuf_rd_addr` out VEC_W: input buffer read, 1-cycle read latency
- `sa_enabled` out 1: array enable; low clears all PE state
- `sa_accept_w` out COLS: per-column north accept flags
- `sa_valid` out ROWS, `sa_switch` out ROWS: per-row west flags
- `out_valid` out COLS: column c bottom-row psum is valid this cycle
- `perf_cycles` out 32: see Configuration

## Operation
- States: IDLE, LOAD_W, SETTLE, STREAM, DRAIN, DONE.
- IDLE -> LOAD_W on `start`, with num_vec clamped to MAX_VEC and then latched as N.
- N==0: IDLE -> DONE directly; no buffer reads; `sa_enabled` stays low.
- LOAD_W, ROWS cycles:
  - `wbuf_rd_en`=1, `wbuf_rd_addr`=0..ROWS-1.
  - `sa_accept_w`=all-ones, delayed 1 cycle to align with read data.
- SETTLE, ROWS cycles: weight propagation through the column. `sa_accept_w` is still high in the first SETTLE cycle (trailing alignment).
- STREAM, N cycles: `ibuf_rd_en`=1, `ibuf_rd_addr`=k for k=0..N-1.
- DRAIN: lasts until the last `out_valid` cycle, then DONE.
- DONE: one cycle, then IDLE.
- `sa_enabled`=1 in LOAD_W through DONE; 0 in IDLE.
- `start` outside IDLE is ignored.
- `abort` in any non-IDLE state, at the next edge:
  - go to IDLE;
  - drop all outputs to 0; `sa_enabled`=0 clears the array;
  - no `done` pulse.
- `abort` and `start` in the same IDLE cycle: `abort` wins; stay in IDLE.
- Counters are sized so the ROWS/COLS/N terminal counts never wrap. Addresses stay in range 0..ROWS-1 and 0..N-1.

## Timing
- L0 is the first LOAD_W cycle (edge after `start`). T0 = L0 + 2·ROWS is the first STREAM cycle.
- `sa_accept_w` high on cycles L0+1 .. L0+ROWS.
- `sa_valid[r]` high on cycles T0+1+r+k, for k=0..N-1.
- `sa_switch[r]` is a single pulse at T0+1+r, coincident with the first valid on row r.
- `out_valid[c]` high on cycles T0+1+k+ROWS+c.
- DRAIN ends at T0+N+ROWS+COLS-1. DONE is the next cycle. `busy` falls the cycle after DONE.
- Reset: every output 0 (including `perf_cycles`); state IDLE. Reset mid-run behaves like `abort`.

## Configuration
- `SYSTOLIC_CTRL_PERF_EN` defined:
  - `perf_cycles` counts cycles with `busy`=1 in the current run.
  - It clears on the IDLE->LOAD_W/DONE transition and holds its value in IDLE.
  - `abort` freezes it at the aborted count.
- Not defined: `perf_cycles` is tied to 0 and the counter is not built.

## Structure
- `tpu_pkg`: `ctrl_state_t` enum (the six states) and the shared `DATA_W`=16 constant.
- Sub-module `sa_skew`: a parameterised per-row shift delay line (row r delayed r cycles). It is instantiated once for `sa_valid` and once for `sa_switch`. `out_valid` comes from a COLS-deep shift line inside `systolic_ctrl`.

## Test plan
- ROWS=COLS=2, `start` with N=3 at cycle 0 -> required response:
  - `wbuf_rd_en` on cycles 1-2; `sa_accept_w`=11 on cycles 2-3;
  - `ibuf_rd_en` on cycles 5-7, addr 0,1,2;
  - `sa_valid[0]` on 6-8, `sa_valid[1]` on 7-9; `sa_switch`[0]@6, [1]@7;
  - `out_valid[0]` on 8-10, `out_valid[1]` on 9-11;
  - `done`@12, `busy` on 1-12; `perf_cycles`=12 with PERF_EN.
- N=0 -> `done` on the cycle after `start`; no `wbuf`/`ibuf` reads; `sa_enabled` stays 0.
- N=300 with MAX_VEC=256 -> exactly 256 `ibuf` reads, last addr 255.
- `start` pulsed during STREAM -> ignored; exactly one `done`.
- `abort` at cycle 6 of the first scenario -> at cycle 7 all outputs 0 and state IDLE; no `done`; `perf_cycles`=6.
- `rst` asserted mid-DRAIN -> all outputs 0 at the next edge. A fresh `start` afterwards reproduces the first scenario's timing exactly.
